speed_ramp_ctrl: RTL and testbench

Motor speed command stage that sits directly upstream of the PWM generator and drives its 3-bit `dutyCycle` input. It accepts target speed/direction commands over a valid/ready handshake. It slews `dutyCycle` one step per ramp interval to limit inrush current. Direction reversal always runs ramp-down to 0, then a dead-time gap, then the `direction` flip.

---
 rtl/speed_ramp_pkg.sv | 33 +++
 rtl/tick_strobe.sv | 37 +++
 rtl/speed_ramp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_speed_ramp_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/speed_ramp_pkg.sv
// Shared types and helpers for the motor speed ramp controller.
package speed_ramp_pkg;

  localparam int SPEED_W = 3;
  localparam logic [SPEED_W-1:0] DUTY_MAX = 3'd7;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    HOLD  = 3'd2,
    BRAKE = 3'd3,
    DEAD  = 3'd4
  } ramp_state_e;

  // Where the controller goes right after a (re)target is loaded.
  function automatic ramp_state_e route_state(input speed_t duty, input logic dir,
                                               input speed_t tgt, input logic tgt_dir);
    ramp_state_e res;
    if (tgt_dir != dir) begin
      if (duty == '0) res = DEAD;
      else            res = BRAKE;
    end else if (tgt == duty) begin
      if (tgt != '0) res = HOLD;
      else           res = IDLE;
    end else begin
      res = RAMP;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_strobe.sv
// Free-running interval counter with synchronous clear and one-cycle strobe.
// RAMP_DEBUG_EN exposes the live count.
module tick_strobe #(
  parameter int               CNT_W = 28,
  parameter logic [CNT_W-1:0] TICKS = 28'd1000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic             strobe
`ifdef RAMP_DEBUG_EN
  ,
  output logic [CNT_W-1:0] count_out
`endif
);

  localparam logic [CNT_W-1:0] LAST = TICKS - 1'b1;

  logic [CNT_W-1:0] count;

  assign strobe = enable && (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable) begin
      if (strobe) count <= '0;
      else        count <= count + 1'b1;
    end
  end

`ifdef RAMP_DEBUG_EN
  assign count_out = count;
`endif

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Slews the PWM duty step toward a commanded speed and sequences direction
// reversal through brake and dead time. RAMP_DEBUG_EN adds debug outputs.
module speed_ramp_ctrl
  import speed_ramp_pkg::*;
#(
  parameter int               CNT_W      = 28,
  parameter logic [CNT_W-1:0] RAMP_TICKS = 28'd1000000,
  parameter logic [CNT_W-1:0] DEAD_TICKS = 28'd500000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SPEED_W-1:0] cmd_speed,
  input  logic               cmd_dir,
  input  logic               estop,
  output logic [SPEED_W-1:0] dutyCycle,
  output logic               direction,
  output logic               at_target
`ifdef RAMP_DEBUG_EN
  ,
  output logic [CNT_W-1:0]   debugCounter,
  output logic [2:0]         debugState
`endif
);

  ramp_state_e state, state_nxt;
  speed_t      target, tgt_nxt, duty_nxt;
  logic        target_dir, tdir_nxt, dir_nxt;
  logic        accept;
  logic        ramp_en, ramp_clr, ramp_stb;
  logic        dead_en, dead_clr, dead_stb;

  // One saturating duty step toward tgt; never wraps past 0 or DUTY_MAX.
  function automatic speed_t step_toward(input speed_t duty, input speed_t tgt);
    speed_t res;
    res = duty;
    if (duty < tgt && duty != DUTY_MAX) res = duty + 1'b1;
    else if (duty > tgt && duty != '0)  res = duty - 1'b1;
    return res;
  endfunction

  assign cmd_ready = (state != DEAD) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign at_target = (dutyCycle == target) && (direction == target_dir);

  always_comb begin
    state_nxt = state;
    duty_nxt  = dutyCycle;
    dir_nxt   = direction;
    tgt_nxt   = target;
    tdir_nxt  = target_dir;
    if (estop) begin
      state_nxt = IDLE;
      duty_nxt  = '0;
      tgt_nxt   = '0;
      tdir_nxt  = direction;
    end else if (accept) begin
      // A command always wins over a coincident strobe: retarget, no step.
      tgt_nxt = cmd_speed;
      if (cmd_speed != '0) tdir_nxt = cmd_dir;
      state_nxt = route_state(dutyCycle, direction, tgt_nxt, tdir_nxt);
    end else begin
      case (state)
        RAMP: begin
          if (target_dir != direction) begin
            state_nxt = BRAKE;
          end else if (ramp_stb) begin
            duty_nxt = step_toward(dutyCycle, target);
            if (duty_nxt == target) begin
              if (target != '0) state_nxt = HOLD;
              else              state_nxt = IDLE;
            end
          end
        end
        BRAKE: begin
          if (target_dir == direction) begin
            state_nxt = route_state(dutyCycle, direction, target, target_dir);
          end else if (dutyCycle == '0) begin
            state_nxt = DEAD;
          end else if (ramp_stb) begin
            duty_nxt = step_toward(dutyCycle, '0);
            if (duty_nxt == '0) state_nxt = DEAD;
          end
        end
        DEAD: begin
          duty_nxt = '0;
          if (dead_stb) begin
            dir_nxt = target_dir;
            if (target != '0) state_nxt = RAMP;
            else              state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      dutyCycle  <= '0;
      direction  <= 1'b0;
      target     <= '0;
      target_dir <= 1'b0;
    end else begin
      state      <= state_nxt;
      dutyCycle  <= duty_nxt;
      direction  <= dir_nxt;
      target     <= tgt_nxt;
      target_dir <= tdir_nxt;
    end
  end

  // Both interval timers restart on every state change so each phase gets full length.
  assign ramp_en  = (state == RAMP) || (state == BRAKE);
  assign ramp_clr = estop || accept || (state_nxt != state);
  assign dead_en  = (state == DEAD);
  assign dead_clr = estop || (state_nxt != state);

`ifdef RAMP_DEBUG_EN
  logic [CNT_W-1:0] ramp_cnt, dead_cnt;
`endif

  tick_strobe #(
    .CNT_W (CNT_W),
    .TICKS (RAMP_TICKS)
  ) u_ramp_tick (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (ramp_clr),
    .enable    (ramp_en),
    .strobe    (ramp_stb)
`ifdef RAMP_DEBUG_EN
    ,
    .count_out (ramp_cnt)
`endif
  );

  tick_strobe #(
    .CNT_W (CNT_W),
    .TICKS (DEAD_TICKS)
  ) u_dead_tick (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (dead_clr),
    .enable    (dead_en),
    .strobe    (dead_stb)
`ifdef RAMP_DEBUG_EN
    ,
    .count_out (dead_cnt)
`endif
  );

`ifdef RAMP_DEBUG_EN
  assign debugCounter = (state == DEAD) ? dead_cnt : ramp_cnt;
  assign debugState   = state;
`endif

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Self-checking bench for speed_ramp_ctrl with short tick intervals.
module tb_speed_ramp_ctrl;

  localparam int RAMP_N = 10;
  localparam int DEAD_N = 5;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_speed = 3'd0;
  logic       cmd_dir   = 1'b0;
  logic       estop     = 1'b0;
  logic       cmd_ready;
  logic [2:0] dutyCycle;
  logic       direction;
  logic       at_target;
`ifdef RAMP_DEBUG_EN
  logic [27:0] debugCounter;
  logic [2:0]  debugState;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: duty/direction/target plus cycles elapsed since the last event.
  int m_duty = 0, m_tgt = 0, m_el = 0;
  bit m_dir = 1'b0, m_tdir = 1'b0, m_dead = 1'b0;

  speed_ramp_ctrl #(
    .CNT_W      (28),
    .RAMP_TICKS (28'd10),
    .DEAD_TICKS (28'd5)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_speed (cmd_speed),
    .cmd_dir   (cmd_dir),
    .estop     (estop),
    .dutyCycle (dutyCycle),
    .direction (direction),
    .at_target (at_target)
`ifdef RAMP_DEBUG_EN
    ,
    .debugCounter (debugCounter),
    .debugState   (debugState)
`endif
  );

  always #5 clock = ~clock;

  function automatic void model_edge();
    bit rdy;
    rdy = !m_dead && !estop;
    if (!reset_n) begin
      m_duty = 0; m_tgt = 0; m_el = 0; m_dir = 0; m_tdir = 0; m_dead = 0;
    end else if (estop) begin
      m_duty = 0; m_tgt = 0; m_el = 0; m_tdir = m_dir; m_dead = 0;
    end else if (cmd_valid && rdy) begin
      m_tgt = int'(cmd_speed);
      if (cmd_speed != 3'd0) m_tdir = cmd_dir;
      m_el = 0;
      if (m_tdir != m_dir && m_duty == 0) m_dead = 1;
    end else if (m_dead) begin
      m_el++;
      if (m_el == DEAD_N) begin
        m_dir = m_tdir; m_dead = 0; m_el = 0;
      end
    end else if (m_tdir != m_dir || m_duty != m_tgt) begin
      m_el++;
      if (m_el == RAMP_N) begin
        m_el = 0;
        if (m_tdir != m_dir) begin
          m_duty--;
          if (m_duty == 0) m_dead = 1;
        end else if (m_duty < m_tgt) begin
          m_duty++;
        end else begin
          m_duty--;
        end
      end
    end else begin
      m_el = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [2:0] spd, input logic dir);
    cmd_valid = 1'b1; cmd_speed = spd; cmd_dir = dir;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; estop = 1'b0; cmd_valid = 1'b0;
    tick(); tick();
    checks++; if (dutyCycle !== 3'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", dutyCycle); end
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_dir got %0b want 0", direction); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target got %0b want 1", at_target); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", cmd_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp_up();
    logic [2:0] e;
    issue(3'd5, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      tick();
      e = 3'((i / 10 > 5) ? 5 : i / 10);
      checks++; if (dutyCycle !== e) begin errors++; $display("FAIL ramp_up_duty t=%0d got %0d want %0d", i, dutyCycle, e); end
      checks++; if (at_target !== (i >= 50)) begin errors++; $display("FAIL ramp_up_at_target t=%0d got %0b want %0b", i, at_target, i >= 50); end
    end
  endtask

  task automatic test_ramp_down();
    logic [2:0] e;
    issue(3'd2, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      e = 3'((5 - i / 10 < 2) ? 2 : 5 - i / 10);
      checks++; if (dutyCycle !== e) begin errors++; $display("FAIL ramp_down_duty t=%0d got %0d want %0d", i, dutyCycle, e); end
      checks++; if (at_target !== (i >= 30)) begin errors++; $display("FAIL ramp_down_at_target t=%0d got %0b want %0b", i, at_target, i >= 30); end
    end
  endtask

  task automatic test_reversal();
    logic [2:0] e;
    issue(3'd3, 1'b0);
    for (int i = 1; i <= 10; i++) tick();
    checks++; if (dutyCycle !== 3'd3) begin errors++; $display("FAIL rev_setup_duty got %0d want 3", dutyCycle); end
    issue(3'd3, 1'b1);
    for (int i = 1; i <= 75; i++) begin
      tick();
      if (i < 35) e = 3'((3 - i / 10 < 0) ? 0 : 3 - i / 10);
      else        e = 3'(((i - 35) / 10 > 3) ? 3 : (i - 35) / 10);
      checks++; if (dutyCycle !== e) begin errors++; $display("FAIL rev_duty t=%0d got %0d want %0d", i, dutyCycle, e); end
      checks++; if (direction !== (i >= 35)) begin errors++; $display("FAIL rev_dir t=%0d got %0b want %0b", i, direction, i >= 35); end
      checks++; if (cmd_ready !== !(i >= 30 && i < 35)) begin errors++; $display("FAIL rev_ready t=%0d got %0b want %0b", i, cmd_ready, !(i >= 30 && i < 35)); end
    end
  endtask

  task automatic test_estop();
    estop = 1'b1; cmd_valid = 1'b1; cmd_speed = 3'd6; cmd_dir = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (dutyCycle !== 3'd0) begin errors++; $display("FAIL estop_duty t=%0d got %0d want 0", i, dutyCycle); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL estop_ready t=%0d got %0b want 0", i, cmd_ready); end
      checks++; if (direction !== 1'b1) begin errors++; $display("FAIL estop_dir t=%0d got %0b want 1", i, direction); end
    end
    estop = 1'b0; cmd_valid = 1'b0;
    tick();
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL estop_release_at_target got %0b want 1", at_target); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL estop_release_ready got %0b want 1", cmd_ready); end
    for (int i = 1; i <= 15; i++) tick();
    checks++; if (dutyCycle !== 3'd0) begin errors++; $display("FAIL estop_idle_duty got %0d want 0", dutyCycle); end
  endtask

  task automatic test_reset_in_dead();
    issue(3'd2, 1'b0);
    tick(); tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL dead_ready got %0b want 0", cmd_ready); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL dead_dir got %0b want 1", direction); end
    reset_n = 1'b0;
    tick();
    checks++; if (dutyCycle !== 3'd0) begin errors++; $display("FAIL dead_reset_duty got %0d want 0", dutyCycle); end
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL dead_reset_dir got %0b want 0", direction); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL dead_reset_ready got %0b want 1", cmd_ready); end
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (direction !== 1'b0 || dutyCycle !== 3'd0) begin errors++; $display("FAIL dead_reset_late t=%0d got dir %0b duty %0d want 0 0", i, direction, dutyCycle); end
    end
  endtask

  task automatic test_retarget();
    logic [2:0] e;
    issue(3'd7, 1'b0);
    for (int i = 1; i <= 20; i++) tick();
    checks++; if (dutyCycle !== 3'd2) begin errors++; $display("FAIL retarget_setup_duty got %0d want 2", dutyCycle); end
    issue(3'd4, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      tick();
      e = (i < 10) ? 3'd2 : (i < 20) ? 3'd3 : 3'd4;
      checks++; if (dutyCycle !== e) begin errors++; $display("FAIL retarget_duty t=%0d got %0d want %0d", i, dutyCycle, e); end
      checks++; if (at_target !== (i >= 20)) begin errors++; $display("FAIL retarget_at_target t=%0d got %0b want %0b", i, at_target, i >= 20); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      reset_n   = ($urandom_range(0, 399) != 0);
      estop     = ($urandom_range(0, 79) == 0) || (estop && ($urandom_range(0, 3) != 0));
      cmd_valid = ($urandom_range(0, 24) == 0);
      cmd_speed = 3'($urandom_range(0, 7));
      cmd_dir   = 1'($urandom_range(0, 1));
      tick();
      checks++; if (dutyCycle !== 3'(m_duty)) begin errors++; $display("FAIL rand_duty c=%0d got %0d want %0d", c, dutyCycle, m_duty); end
      checks++; if (direction !== m_dir) begin errors++; $display("FAIL rand_dir c=%0d got %0b want %0b", c, direction, m_dir); end
      checks++; if (at_target !== (m_duty == m_tgt && m_dir == m_tdir)) begin errors++; $display("FAIL rand_at_target c=%0d got %0b want %0b", c, at_target, (m_duty == m_tgt && m_dir == m_tdir)); end
      checks++; if (cmd_ready !== (!m_dead && !estop)) begin errors++; $display("FAIL rand_ready c=%0d got %0b want %0b", c, cmd_ready, (!m_dead && !estop)); end
    end
    reset_n = 1'b1; estop = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_estop();
    test_reset_in_dead();
    test_retarget();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before bench completed");
    $fatal(1, "watchdog");
  end

endmodule
